pavana_resp_sequencer_param: RTL and testbench
==============================================

Name: pavana_resp_sequencer_param

Overview:
- Parametrised in-order read-response sequencer, one instance per master port in the pavana crossbar family.
- Records the target slave number of every read the crossbar accepts for its master.
- Buffers responses that arrive out of order from NUM_SLAVES slaves, and returns them to the master strictly in issue order.
- Successor to the fixed 4-slave/4-entry sequencer: slave count, data width and both buffer depths are parameters. Adds per-slave response buffering, an outstanding-read count, overflow error flags and an optional same-cycle bypass.

Parameters:
- NUM_SLAVES, 4, number of slave response inputs (2..16).
- SNUM_WIDTH, 2, slave-number width; must equal clog2(NUM_SLAVES).
- DATA_WIDTH, 32, read data width.
- TAG_DEPTH_ORDER, 2, tag FIFO holds 2^TAG_DEPTH_ORDER outstanding reads.
- RESP_DEPTH_ORDER, 1, each per-slave response buffer holds 2^RESP_DEPTH_ORDER entries.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- tag_wr_i  in  1  read request accepted for this master this cycle.
- tag_snum_i  in  SNUM_WIDTH  target slave of that read.
- tag_full_o  out  1  tag FIFO full (registered); crossbar gates read requests with it.
- tag_empty_o  out  1  no outstanding reads.
- outstanding_o  out  TAG_DEPTH_ORDER+1  number of outstanding reads.
- slv_resp_i  in  NUM_SLAVES  per-slave response strobe, already routed to this master.
- slv_rdata_i  in  NUM_SLAVES*DATA_WIDTH  flattened response data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- mst_resp_o  out  1  response valid to master, one-cycle pulse per read.
- mst_rdata_o  out  DATA_WIDTH  response data; holds its last value while mst_resp_o=0.
- err_o  out  2  sticky errors: bit0 response-buffer overflow, bit1 tag-FIFO overflow.

Behaviour:
- Reset (rst_i=0, asynchronous, any time including mid-operation): all FIFOs emptied; mst_resp_o=0, mst_rdata_o=0, err_o=0, tag_full_o=0, tag_empty_o=1, outstanding_o=0. All in-flight state is discarded.
- Tag FIFO: tag_wr_i pushes tag_snum_i.
  - Full is the registered state; a write while full is accepted only if a pop occurs in the same cycle.
  - Otherwise the write is dropped and err_o[1] is set.
- outstanding_o = tag FIFO occupancy, range 0..2^TAG_DEPTH_ORDER. It is updated on the edge, +1 on push, -1 on pop, unchanged when both occur.
- Response buffers: slv_resp_i[k] pushes slave k's data into buffer k.
  - Buffer k full with no same-cycle pop of k: data dropped, err_o[0] set.
  - Several slaves may push in the same cycle; all are accepted.
- Head selection: head slave h = tag FIFO head. A pop is eligible when the tag FIFO is non-empty and buffer h is non-empty.
  - On the edge, pop the tag FIFO and buffer h.
  - Register mst_rdata_o = buffer h head and pulse mst_resp_o=1.
- Latency (bypass off): 2 cycles from slv_resp_i[h] to mst_resp_o. Throughput is 1 response per cycle.
- Ordering: responses leave in tag order regardless of arrival order. Responses from the same slave leave in arrival order.
- Constraint on the slave side: a response must arrive no earlier than the cycle after its tag was written. Violations are unspecified.
- Error flags: err_o bits clear only on reset.
- SNUM_WIDTH vs NUM_SLAVES: if tag_snum_i >= NUM_SLAVES when NUM_SLAVES is not a power of two, the tag is still stored. It blocks the FIFO head permanently; the verifier checks this via an assertion, not recovery.

Optional Feature:
- Macro: PAVANA_SEQ_BYPASS_EN.
- Defined: when the tag FIFO is non-empty, buffer h is empty and slv_resp_i[h]=1, the data goes directly to the output register. The tag pops and buffer h is not written; latency is 1 cycle. Other slaves' strobes in that cycle are buffered normally.
- Undefined: every response passes through its buffer, giving a fixed 2-cycle latency.

Decomposition:
- Shared package pavana_xbar_pkg:
  - clog2 function.
  - Default SNUM_WIDTH, DATA_WIDTH and depth-order constants.
  - Error-bit indices ERR_RESP_OVF=0, ERR_TAG_OVF=1.
- One sub-module: pavana_sync_fifo (width, depth order, async active-low reset, full/empty/count outputs, simultaneous push/pop when full).
  - Instantiated once for the tag FIFO.
  - Instantiated NUM_SLAVES times by generate for the response buffers.

Test Plan:
- Reset mid-operation: 3 tags outstanding, 1 buffered response, rst_i low for 1 cycle -> outputs all 0, tag_empty_o=1, outstanding_o=0; a following single read round-trips normally.
- Reordering: tags 2 then 0; slave0 data 0xAAAA0000 at cycle t, slave2 data 0x22222222 at t+2 -> bypass on: mst_resp_o at t+3 with 0x22222222, then t+4 with 0xAAAA0000. Bypass off: t+4 and t+5.
- Tag full: 4 writes to slave 3 -> tag_full_o=1, outstanding_o=4.
  - A 5th write with no pop -> dropped, err_o=2'b10, outstanding_o stays 4.
  - A write coinciding with a pop -> accepted, outstanding_o stays 4.
- Buffer overflow (RESP_DEPTH_ORDER=1): tags 1,0,0,0; three slave0 responses before any slave1 response -> third dropped, err_o[0]=1. Slave1 response then releases 3 responses in order.
- Throughput: 4 tags to slave 1, responses 0x1,0x2,0x3,0x4 on consecutive cycles -> mst_resp_o high 4 consecutive cycles with data 0x1..0x4.
- Simultaneous arrivals: tags 0,1,2,3; all four slaves respond in one cycle with 0x10,0x11,0x12,0x13 -> 4 consecutive outputs in order 0x10..0x13, err_o=0.

Source files
------------

// File: rtl/pavana_xbar_pkg.sv
// Shared definitions for the pavana crossbar family: default widths/depths,
// error-bit indices and a constant clog2 helper.
package pavana_xbar_pkg;

   localparam int DEF_NUM_SLAVES       = 4;
   localparam int DEF_SNUM_WIDTH       = 2;
   localparam int DEF_DATA_WIDTH       = 32;
   localparam int DEF_TAG_DEPTH_ORDER  = 2;
   localparam int DEF_RESP_DEPTH_ORDER = 1;

   localparam int ERR_RESP_OVF = 0;
   localparam int ERR_TAG_OVF  = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pavana_sync_fifo.sv
// Synchronous FIFO, 2^DEPTH_ORDER entries, async active-low reset.
// A push while full is taken only when a pop happens in the same cycle.
module pavana_sync_fifo #(
   parameter int WIDTH       = 32,
   parameter int DEPTH_ORDER = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [DEPTH_ORDER:0]   count_o
);

   localparam int DEPTH = 1 << DEPTH_ORDER;
   localparam logic [DEPTH_ORDER:0] DEPTH_CNT = (DEPTH_ORDER + 1)'(DEPTH);

   logic [WIDTH-1:0]       mem [DEPTH];
   logic [DEPTH_ORDER-1:0] wr_ptr;
   logic [DEPTH_ORDER-1:0] rd_ptr;
   logic [DEPTH_ORDER:0]   count;
   logic                   do_push;
   logic                   do_pop;

   assign do_pop  = pop_i && (count != '0);
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; contents are only observed while count is non-zero.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata_i;
   end

   assign rdata_o = mem[rd_ptr];
   assign full_o  = (count == DEPTH_CNT);
   assign empty_o = (count == '0);
   assign count_o = count;

endmodule

// File: rtl/pavana_resp_sequencer_param.sv
// In-order read-response sequencer for one pavana crossbar master port.
// Optional same-cycle bypass of the head slave's buffer: `define PAVANA_SEQ_BYPASS_EN.
module pavana_resp_sequencer_param
   import pavana_xbar_pkg::*;
#(
   parameter int NUM_SLAVES       = DEF_NUM_SLAVES,
   parameter int SNUM_WIDTH       = DEF_SNUM_WIDTH,
   parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
   parameter int TAG_DEPTH_ORDER  = DEF_TAG_DEPTH_ORDER,
   parameter int RESP_DEPTH_ORDER = DEF_RESP_DEPTH_ORDER
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             tag_wr_i,
   input  logic [SNUM_WIDTH-1:0]            tag_snum_i,
   output logic                             tag_full_o,
   output logic                             tag_empty_o,
   output logic [TAG_DEPTH_ORDER:0]         outstanding_o,
   input  logic [NUM_SLAVES-1:0]            slv_resp_i,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata_i,
   output logic                             mst_resp_o,
   output logic [DATA_WIDTH-1:0]            mst_rdata_o,
   output logic [1:0]                       err_o
);

   // Handshake: all strobes are single-cycle valids with no ready. The crossbar
   // must gate tag_wr_i with tag_full_o; the master always takes mst_resp_o.

   logic [SNUM_WIDTH-1:0]       head_snum;
   logic                        tag_pop;
   logic [NUM_SLAVES-1:0]       head_sel;
   logic [NUM_SLAVES-1:0]       buf_push;
   logic [NUM_SLAVES-1:0]       buf_pop;
   logic [NUM_SLAVES-1:0]       buf_full;
   logic [NUM_SLAVES-1:0]       buf_empty;
   logic [DATA_WIDTH-1:0]       buf_rdata [NUM_SLAVES];
   logic [RESP_DEPTH_ORDER:0]   buf_count_unused [NUM_SLAVES];
   logic [DATA_WIDTH-1:0]       head_data;
   logic                        head_ready;
   logic                        bypass;
   logic [DATA_WIDTH-1:0]       bypass_data;
   logic                        resp_ovf;
   logic                        tag_ovf;

   pavana_sync_fifo #(.WIDTH(SNUM_WIDTH), .DEPTH_ORDER(TAG_DEPTH_ORDER)) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (tag_wr_i),
      .pop_i   (tag_pop),
      .wdata_i (tag_snum_i),
      .rdata_o (head_snum),
      .full_o  (tag_full_o),
      .empty_o (tag_empty_o),
      .count_o (outstanding_o)
   );

   for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_resp_buf
      pavana_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_ORDER(RESP_DEPTH_ORDER)) u_resp_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (buf_push[k]),
         .pop_i   (buf_pop[k]),
         .wdata_i (slv_rdata_i[k*DATA_WIDTH +: DATA_WIDTH]),
         .rdata_o (buf_rdata[k]),
         .full_o  (buf_full[k]),
         .empty_o (buf_empty[k]),
         .count_o (buf_count_unused[k])
      );
   end

   // A head tag naming a slave beyond NUM_SLAVES selects nothing and stalls forever.
   always_comb begin
      head_sel  = '0;
      head_data = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         head_sel[k] = !tag_empty_o && (int'(head_snum) == k);
         if (head_sel[k]) head_data = buf_rdata[k];
      end
      buf_pop    = head_sel & ~buf_empty;
      head_ready = |buf_pop;
   end

`ifdef PAVANA_SEQ_BYPASS_EN
   always_comb begin
      bypass_data = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (head_sel[k]) bypass_data = slv_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      bypass = |(head_sel & buf_empty & slv_resp_i);
   end
`else
   assign bypass      = 1'b0;
   assign bypass_data = '0;
`endif

   assign tag_pop  = head_ready || bypass;
   assign buf_push = slv_resp_i & ~({NUM_SLAVES{bypass}} & head_sel);
   assign resp_ovf = |(buf_push & buf_full & ~buf_pop);
   assign tag_ovf  = tag_wr_i && tag_full_o && !tag_pop;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mst_resp_o  <= 1'b0;
         mst_rdata_o <= '0;
         err_o       <= '0;
      end else begin
         mst_resp_o <= tag_pop;
         if (head_ready)  mst_rdata_o <= head_data;
         else if (bypass) mst_rdata_o <= bypass_data;
         if (resp_ovf) err_o[ERR_RESP_OVF] <= 1'b1;
         if (tag_ovf)  err_o[ERR_TAG_OVF]  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pavana_resp_sequencer_param.sv
// Directed bench for pavana_resp_sequencer_param (default parameters); expected
// responses are queued in issue order and compared as the master port emits them.
module tb_pavana_resp_sequencer_param;

`ifdef PAVANA_SEQ_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         tag_wr;
   logic [1:0]   tag_snum;
   logic         tag_full;
   logic         tag_empty;
   logic [2:0]   outstanding;
   logic [3:0]   slv_resp;
   logic [127:0] slv_rdata;
   logic         mst_resp;
   logic [31:0]  mst_rdata;
   logic [1:0]   err;

   logic [31:0]  exp_q[$];
   int           resp_cyc[$];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;

   pavana_resp_sequencer_param dut (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .tag_wr_i      (tag_wr),
      .tag_snum_i    (tag_snum),
      .tag_full_o    (tag_full),
      .tag_empty_o   (tag_empty),
      .outstanding_o (outstanding),
      .slv_resp_i    (slv_resp),
      .slv_rdata_i   (slv_rdata),
      .mst_resp_o    (mst_resp),
      .mst_rdata_o   (mst_rdata),
      .err_o         (err)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // scoreboard: every response pulse must match the oldest expected value
   always @(negedge clk) begin
      if (mst_resp) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_resp: observed data %08h, expected no response", mst_rdata);
         end
         if (exp_q.size() != 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            assert (mst_rdata === e) else begin
               errors++;
               $error("FAIL resp_data: observed %08h expected %08h", mst_rdata, e);
            end
         end
         resp_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] put(input int k, input logic [31:0] v);
      logic [127:0] r;
      r = '0;
      r[k*32 +: 32] = v;
      return r;
   endfunction

   // driver tasks: each call owns one clock cycle of input values
   task automatic drive(input logic tw, input logic [1:0] sn, input logic [3:0] rs,
                        input logic [127:0] rd);
      @(posedge clk);
      #1;
      tag_wr    = tw;
      tag_snum  = sn;
      slv_resp  = rs;
      slv_rdata = rd;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 2'd0, 4'b0000, '0);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      @(negedge clk);
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_mst_resp"}, 64'(mst_resp), 64'd0);
      check({tag, "_mst_rdata"}, 64'(mst_rdata), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_tag_full"}, 64'(tag_full), 64'd0);
      check({tag, "_tag_empty"}, 64'(tag_empty), 64'd1);
      check({tag, "_outstanding"}, 64'(outstanding), 64'd0);
   endtask

   task automatic pulse_reset(input string tag);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      tag_wr = 1'b0; tag_snum = '0; slv_resp = '0; slv_rdata = '0;
      @(negedge clk);
      check_reset_state(tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic int cyc_at(input int idx);
      return (resp_cyc.size() > idx) ? resp_cyc[idx] : -1;
   endfunction

   task automatic round_trip(input string tag, input logic [1:0] sn, input logic [31:0] v);
      int t;
      int base;
      base = resp_cyc.size();
      drive(1'b1, sn, 4'b0000, '0);
      drive(1'b0, 2'd0, 4'b0001 << sn, put(int'(sn), v));
      t = cyc;
      exp_q.push_back(v);
      idle(1);
      wait_drain({tag, "_drain"}, 20);
      check({tag, "_latency"}, 64'(cyc_at(base)), 64'(t + LAT));
      check({tag, "_empty"}, 64'(tag_empty), 64'd1);
      check({tag, "_outstanding"}, 64'(outstanding), 64'd0);
   endtask

   initial begin
      int t;
      int base;
      rst_n = 1'b0;
      tag_wr = 1'b0; tag_snum = '0; slv_resp = '0; slv_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state("por");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      round_trip("single", 2'd1, 32'h1234_5678);

      // reordering: tags 2 then 0, slave0 answers first
      base = resp_cyc.size();
      drive(1'b1, 2'd2, 4'b0000, '0);
      drive(1'b1, 2'd0, 4'b0000, '0);
      drive(1'b0, 2'd0, 4'b0001, put(0, 32'hAAAA_0000));
      t = cyc;
      idle(1);
      drive(1'b0, 2'd0, 4'b0100, put(2, 32'h2222_2222));
      exp_q.push_back(32'h2222_2222);
      exp_q.push_back(32'hAAAA_0000);
      idle(1);
      wait_drain("reorder_drain", 20);
      check("reorder_first_cyc", 64'(cyc_at(base)), 64'(t + LAT + 2));
      check("reorder_second_cyc", 64'(cyc_at(base + 1)), 64'(t + LAT + 3));

      // tag FIFO full, dropped write, write coinciding with a pop
      repeat (4) drive(1'b1, 2'd3, 4'b0000, '0);
      idle(1);
      @(negedge clk);
      check("full_flag", 64'(tag_full), 64'd1);
      check("full_outstanding", 64'(outstanding), 64'd4);
      drive(1'b1, 2'd3, 4'b0000, '0);
      idle(1);
      @(negedge clk);
      check("tag_ovf_err", 64'(err), 64'd2);
      check("tag_ovf_outstanding", 64'(outstanding), 64'd4);
      exp_q.push_back(32'h0000_3001);
`ifdef PAVANA_SEQ_BYPASS_EN
      drive(1'b1, 2'd3, 4'b1000, put(3, 32'h0000_3001));
`else
      drive(1'b0, 2'd0, 4'b1000, put(3, 32'h0000_3001));
      drive(1'b1, 2'd3, 4'b0000, '0);
`endif
      idle(1);
      @(negedge clk);
      check("pop_write_outstanding", 64'(outstanding), 64'd4);
      check("pop_write_full", 64'(tag_full), 64'd1);
      for (int i = 2; i <= 5; i++) begin
         exp_q.push_back(32'h0000_3000 + 32'(i));
         drive(1'b0, 2'd0, 4'b1000, put(3, 32'h0000_3000 + 32'(i)));
      end
      idle(1);
      wait_drain("full_drain", 20);
      check("full_drain_outstanding", 64'(outstanding), 64'd0);
      check("tag_err_sticky", 64'(err), 64'd2);
      pulse_reset("rst_after_full");

      // response buffer overflow on slave0
      drive(1'b1, 2'd1, 4'b0000, '0);
      repeat (3) drive(1'b1, 2'd0, 4'b0000, '0);
      drive(1'b0, 2'd0, 4'b0001, put(0, 32'h0A0A_0001));
      drive(1'b0, 2'd0, 4'b0001, put(0, 32'h0A0A_0002));
      drive(1'b0, 2'd0, 4'b0001, put(0, 32'h0A0A_0003));
      idle(1);
      @(negedge clk);
      check("resp_ovf_err", 64'(err), 64'd1);
      check("resp_ovf_outstanding", 64'(outstanding), 64'd4);
      exp_q.push_back(32'h0B0B_0001);
      exp_q.push_back(32'h0A0A_0001);
      exp_q.push_back(32'h0A0A_0002);
      drive(1'b0, 2'd0, 4'b0010, put(1, 32'h0B0B_0001));
      idle(1);
      wait_drain("ovf_release_drain", 20);
      idle(2);
      @(negedge clk);
      check("ovf_left_outstanding", 64'(outstanding), 64'd1);
      exp_q.push_back(32'h0A0A_0004);
      drive(1'b0, 2'd0, 4'b0001, put(0, 32'h0A0A_0004));
      idle(1);
      wait_drain("ovf_final_drain", 20);
      check("ovf_final_outstanding", 64'(outstanding), 64'd0);
      check("resp_err_sticky", 64'(err), 64'd1);
      pulse_reset("rst_after_ovf");

      // back-to-back throughput from one slave
      base = resp_cyc.size();
      repeat (4) drive(1'b1, 2'd1, 4'b0000, '0);
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(32'(i));
         drive(1'b0, 2'd0, 4'b0010, put(1, 32'(i)));
         if (i == 1) t = cyc;
      end
      idle(1);
      wait_drain("tput_drain", 20);
      check("tput_first_cyc", 64'(cyc_at(base)), 64'(t + LAT));
      for (int i = 1; i < 4; i++)
         check("tput_consecutive", 64'(cyc_at(base + i)), 64'(cyc_at(base) + i));

      // all four slaves answer in one cycle
      base = resp_cyc.size();
      for (int s = 0; s < 4; s++) drive(1'b1, 2'(s), 4'b0000, '0);
      for (int s = 0; s < 4; s++) exp_q.push_back(32'h10 + 32'(s));
      drive(1'b0, 2'd0, 4'b1111, {32'h13, 32'h12, 32'h11, 32'h10});
      idle(1);
      wait_drain("simul_drain", 20);
      for (int i = 1; i < 4; i++)
         check("simul_consecutive", 64'(cyc_at(base + i)), 64'(cyc_at(base) + i));
      check("simul_err", 64'(err), 64'd0);

      // reset in the middle of traffic discards everything in flight
      drive(1'b1, 2'd0, 4'b0000, '0);
      drive(1'b1, 2'd1, 4'b0000, '0);
      drive(1'b1, 2'd2, 4'b0000, '0);
      drive(1'b0, 2'd0, 4'b0100, put(2, 32'h5555_5555));
      idle(1);
      @(negedge clk);
      check("midrst_pre_outstanding", 64'(outstanding), 64'd3);
      pulse_reset("midrst");
      round_trip("post_rst", 2'd2, 32'h600D_0001);

      idle(4);
      @(negedge clk);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
